// File: rtl/irq_ctrl.sv
`default_nettype none
// irq_ctrl: memory-mapped interrupt controller driving a single CP0 hw_int line.
// Define IRQ_PRIO_ROTATE_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module irq_ctrl #(
    parameter int SRC_N   = 8,
    parameter int HW_LINE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SRC_N-1:0] src_irq,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [5:0]       hw_int
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t           state_q;
    logic [SRC_N-1:0] pend_q;
    logic [SRC_N-1:0] pend_d;
    logic [SRC_N-1:0] mask_q;
    logic [SRC_N-1:0] edge_q;
    logic [SRC_N-1:0] src_prev_q;
    logic [4:0]       id_q;
    logic             valid_q;
    logic             line_q;

    logic [SRC_N-1:0] elig;
    logic [SRC_N-1:0] scan;
    logic             wr_pend;
    logic             wr_mask;
    logic             wr_edge;
    logic             ack;
    logic             any_elig;
    logic [4:0]       off;
    logic [4:0]       pick;
    logic             unused_ok;

`ifdef IRQ_PRIO_ROTATE_EN
    logic [4:0]       rr_ptr_q;
    logic [4:0]       start;
`endif

    assign wr_pend   = we & (addr[3:2] == 2'd0);
    assign wr_mask   = we & (addr[3:2] == 2'd1);
    assign wr_edge   = we & (addr[3:2] == 2'd2);
    assign ack       = we & (addr[3:2] == 2'd3) & (state_q == S_ASSERT);
    assign elig      = pend_q & mask_q;
    assign hw_int    = 6'(line_q) << HW_LINE;
    assign unused_ok = &{1'b0, addr[1:0], wdata[31:SRC_N]};

    // Rotate the eligible vector so a plain lowest-index scan implements either policy.
    always_comb begin
`ifdef IRQ_PRIO_ROTATE_EN
        start = (rr_ptr_q == 5'(SRC_N-1)) ? 5'd0 : rr_ptr_q + 5'd1;
        scan  = SRC_N'({elig, elig} >> start);
`else
        scan  = elig;
`endif
        any_elig = 1'b0;
        off      = 5'd0;
        for (int k = 0; k < SRC_N; k++) begin
            if (!any_elig && scan[k]) begin
                any_elig = 1'b1;
                off      = 5'(k);
            end
        end
`ifdef IRQ_PRIO_ROTATE_EN
        pick = start + off;
        if (pick >= 5'(SRC_N)) begin
            pick = pick - 5'(SRC_N);
        end
`else
        pick = off;
`endif
    end

    // Edge bits: set beats any same-cycle clear (W1C or ACK of the active id).
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < SRC_N; i++) begin
            if (edge_q[i]) begin
                pend_d[i] = (src_irq[i] & ~src_prev_q[i])
                          | (pend_q[i] & ~((wr_pend & wdata[i]) | (ack & (id_q == 5'(i)))));
            end else begin
                pend_d[i] = src_irq[i];
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = 32'(pend_q);
            2'd1:    rdata = 32'(mask_q);
            2'd2:    rdata = 32'(edge_q);
            default: rdata = {valid_q, 26'd0, id_q};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            src_prev_q <= '0;
        end else begin
            pend_q     <= pend_d;
            src_prev_q <= src_irq;
            if (wr_mask) begin
                mask_q <= wdata[SRC_N-1:0];
            end
            if (wr_edge) begin
                edge_q <= wdata[SRC_N-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            id_q     <= 5'd0;
            valid_q  <= 1'b0;
            line_q   <= 1'b0;
`ifdef IRQ_PRIO_ROTATE_EN
            rr_ptr_q <= 5'(SRC_N-1);
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        id_q     <= pick;
                        valid_q  <= 1'b1;
                        line_q   <= 1'b1;
                        state_q  <= S_ASSERT;
`ifdef IRQ_PRIO_ROTATE_EN
                        rr_ptr_q <= pick;
`endif
                    end
                end
                S_ASSERT: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        line_q  <= 1'b0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    line_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// tb_irq_ctrl: directed scenarios with literal expectations plus randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_ctrl;
    localparam int SRC_N   = 8;
    localparam int HW_LINE = 2;
    localparam logic [3:0] A_PEND = 4'h0;
    localparam logic [3:0] A_MASK = 4'h4;
    localparam logic [3:0] A_EDGE = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [SRC_N-1:0] src_irq = '0;
    logic             we    = 1'b0;
    logic [3:0]       addr  = 4'h0;
    logic [31:0]      wdata = 32'h0;
    logic [31:0]      rdata;
    logic [5:0]       hw_int;

    irq_ctrl #(.SRC_N(SRC_N), .HW_LINE(HW_LINE)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .hw_int  (hw_int)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: register arrays plus "is an interrupt being held" and "gap cycle pending".
    bit m_pend [SRC_N];
    bit m_mask [SRC_N];
    bit m_edge [SRC_N];
    bit m_prev [SRC_N];
    bit m_active;
    bit m_valid;
    bit m_gap;
    int m_id;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < SRC_N; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0; m_prev[i] = 0;
        end
        m_active = 0; m_valid = 0; m_gap = 0; m_id = 0; m_last = SRC_N - 1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < SRC_N; i++) begin
            case (a[3:2])
                2'd0: v[i] = m_pend[i];
                2'd1: v[i] = m_mask[i];
                2'd2: v[i] = m_edge[i];
                default: ;
            endcase
        end
        if (a[3:2] == 2'd3) v = {m_valid, 26'd0, 5'(m_id)};
        return v;
    endfunction

    function automatic logic [5:0] m_hw();
        return m_active ? (6'd1 << HW_LINE) : 6'd0;
    endfunction

    function automatic void model_step();
        bit np [SRC_N];
        int sel   = int'(addr[3:2]);
        bit ackq  = we && (sel == 3) && m_active;
        int found = -1;
        for (int i = 0; i < SRC_N; i++) begin
            if (m_edge[i]) begin
                bit set_b = src_irq[i] && !m_prev[i];
                bit clr_b = (we && sel == 0 && wdata[i]) || (ackq && m_id == i);
                np[i] = set_b || (m_pend[i] && !clr_b);
            end else begin
                np[i] = src_irq[i];
            end
        end
        for (int k = 0; k < SRC_N; k++) begin
            int j;
`ifdef IRQ_PRIO_ROTATE_EN
            j = (m_last + 1 + k) % SRC_N;
`else
            j = k;
`endif
            if (found < 0 && m_pend[j] && m_mask[j]) found = j;
        end
        if (m_active) begin
            if (ackq) begin
                m_active = 0; m_valid = 0; m_gap = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (found >= 0) begin
            m_active = 1; m_valid = 1; m_id = found; m_last = found;
        end
        for (int i = 0; i < SRC_N; i++) begin
            if (we && sel == 1) m_mask[i] = wdata[i];
            if (we && sel == 2) m_edge[i] = wdata[i];
            m_pend[i] = np[i];
            m_prev[i] = src_irq[i];
        end
    endfunction

    // One clock: drive at the falling edge, compare, then advance the model on the rising edge.
    task automatic tick(input logic [SRC_N-1:0] s, input logic w, input logic [3:0] a, input logic [31:0] d);
        src_irq = s; we = w; addr = a; wdata = d;
        #1;
        chk("hw_int", 32'(hw_int), 32'(m_hw()));
        chk("rdata", rdata, m_rdata(addr));
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [31:0] e);
        we = 1'b0; addr = a;
        #1;
        chk(name, rdata, e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick('0, 1'b0, A_PEND, 32'h0);
        reset = 1'b0;
    endtask

    logic [SRC_N-1:0] rs;
    logic [31:0]      rd;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_hw_int", 32'(hw_int), 32'h0);
        peek("reset_ctrl", A_CTRL, 32'h0);

        // Edge source 0 pulse -> hw_int two edges later, then ACK.
        tick('0, 1'b1, A_MASK, 32'h01);
        tick('0, 1'b1, A_EDGE, 32'h01);
        tick(8'h01, 1'b0, A_PEND, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        chk("s1_hw_int_high", 32'(hw_int), 32'h4);
        peek("s1_ctrl", A_CTRL, 32'h8000_0000);
        tick(8'h00, 1'b1, A_CTRL, 32'h0);
        chk("s1_hw_int_after_ack", 32'(hw_int), 32'h0);
        peek("s1_pend_after_ack", A_PEND, 32'h0);

        // Simultaneous edges on 5 and 2: 2 first, then 5 after the gap.
        do_reset();
        tick('0, 1'b1, A_MASK, 32'hFF);
        tick('0, 1'b1, A_EDGE, 32'hFF);
        tick(8'h24, 1'b0, A_PEND, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        peek("s2_first_id", A_CTRL, 32'h8000_0002);
        tick(8'h00, 1'b1, A_CTRL, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        chk("s2_gap_low", 32'(hw_int), 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        peek("s2_second_id", A_CTRL, 32'h8000_0005);
        tick(8'h00, 1'b1, A_CTRL, 32'h0);

        // Level source 4 drops during ASSERT: line held until ACK, then nothing eligible.
        do_reset();
        tick('0, 1'b1, A_MASK, 32'h10);
        tick(8'h10, 1'b0, A_PEND, 32'h0);
        tick(8'h10, 1'b0, A_PEND, 32'h0);
        chk("s3_hw_int_high", 32'(hw_int), 32'h4);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        chk("s3_hw_int_held", 32'(hw_int), 32'h4);
        tick(8'h00, 1'b1, A_CTRL, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        chk("s3_hw_int_idle", 32'(hw_int), 32'h0);
        peek("s3_ctrl", A_CTRL, 32'h0000_0004);

        // Edge set collides with W1C: set wins. ACK in IDLE does nothing.
        do_reset();
        tick('0, 1'b1, A_EDGE, 32'h02);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        tick(8'h02, 1'b1, A_PEND, 32'h02);
        peek("s4_set_wins", A_PEND, 32'h02);
        tick(8'h02, 1'b1, A_CTRL, 32'h0);
        peek("s4_ack_idle_ctrl", A_CTRL, 32'h0);
        chk("s4_ack_idle_hw", 32'(hw_int), 32'h0);

        // Reset in the middle of ASSERT drops the line asynchronously.
        do_reset();
        tick('0, 1'b1, A_MASK, 32'h01);
        tick('0, 1'b1, A_EDGE, 32'h01);
        tick(8'h01, 1'b0, A_PEND, 32'h0);
        tick(8'h00, 1'b0, A_PEND, 32'h0);
        chk("s5_hw_int_high", 32'(hw_int), 32'h4);
        #1 reset = 1'b1;
        #1 chk("s5_async_drop", 32'(hw_int), 32'h0);
        model_reset();
        @(negedge clk);
        peek("s5_mask_rst", A_MASK, 32'h0);
        peek("s5_pend_rst", A_PEND, 32'h0);
        peek("s5_ctrl_rst", A_CTRL, 32'h0);
        tick('0, 1'b0, A_PEND, 32'h0);
        reset = 1'b0;

        // Randomized traffic against the model.
        rs = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) rs = rs ^ SRC_N'($urandom);
            rd = $urandom;
            tick(rs, ($urandom_range(0, 3) == 0), 4'($urandom), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between peripheral interrupt sources and the CP0 `hw_int[5:0]` inputs. It latches up to `SRC_N` source requests and applies per-source masking and edge/level selection. It arbitrates one active interrupt at a time and holds the chosen CP0 hardware line high until the handler acknowledges over the bridge bus. It sits on the system bridge next to the timers, and its `hw_int` output feeds CP0 directly.

## Interface
- `SRC_N`, 8: number of interrupt sources, legal range 2..16.
- `HW_LINE`, 2: index of the `hw_int` bit driven by this block; the other five bits are tied to 0.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `src_irq`  in  SRC_N  source request lines, synchronous to `clk`.
- `we`  in  1  bus write strobe, one cycle per write.
- `addr`  in  4  byte offset in the block; only `addr[3:2]` is decoded.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  bus read data, combinational from `addr` and current state.
- `hw_int`  out  6  to CP0; only bit `HW_LINE` can be high; registered.

## Operation
- Register map (`addr[3:2]`):
  - 0 PEND: read pending bits. Writing 1 clears an edge-mode bit (W1C); writes to level-mode bits are ignored.
  - 1 MASK: read/write; 1 = source enabled.
  - 2 EDGE: read/write; 1 = rising-edge source, 0 = level source.
  - 3 CTRL: read returns `{valid, 26'b0, id[4:0]}`; a write with any data is ACK.
- Bits at index `SRC_N` and above read as 0 and ignore writes.
- Pending update:
  - Edge source: a 1 in `src_irq & ~src_prev` sets PEND. Clearing is by W1C or ACK. When a set and a clear hit the same bit in the same cycle, set wins.
  - Level source: PEND bit is `src_irq` registered each cycle.
- Eligible sources are `PEND & MASK`.
- State machine:
  - IDLE: if any source is eligible, latch its index into `id`, set `valid`, and go to ASSERT. Otherwise stay.
  - ASSERT: `hw_int[HW_LINE]`=1. The `id` is frozen even if the source is masked or its level drops. On ACK, clear PEND[`id`] if it is edge mode, clear `valid`, and go to GAP.
  - GAP: `hw_int`=0 for one cycle, then go to IDLE.
- ACK outside ASSERT is ignored.
- A W1C to the active edge bit during ASSERT clears PEND but does not leave ASSERT.
- Arbitration: fixed priority, lowest index wins; the alternative is set under Configuration.

## Timing
- Reset values: `hw_int`=0, PEND=0, MASK=0, EDGE=0, `src_prev`=0, state=IDLE, `id`=0, `valid`=0, round-robin pointer=`SRC_N-1`.
- While in reset, `rdata` decodes the reset register values.
- Latency from `src_irq` to `hw_int`:
  - A source edge at cycle n sets PEND at edge n+1.
  - IDLE→ASSERT occurs at edge n+2.
  - `hw_int` is high from that point, i.e. 2 edges after the source is sampled.
- ACK written at edge k: `hw_int` is low after k, GAP occupies k..k+1, and IDLE re-arbitrates at k+1.
- Back-to-back interrupts therefore show `hw_int` low for at least 2 cycles.
- Bus writes take effect at the write edge. `rdata` reflects register state before that edge.
- Reset asserted mid-ASSERT drops `hw_int` immediately (asynchronously) and clears all state.

## Configuration
- `IRQ_PRIO_ROTATE_EN` defined: round-robin arbitration.
  - The search starts at `(last_granted+1) mod SRC_N`.
  - `last_granted` updates on entry to ASSERT.
  - The pointer resets to `SRC_N-1`, so the first grant after reset favours source 0.
- `IRQ_PRIO_ROTATE_EN` undefined: fixed priority, lowest index wins; no pointer register exists.

## Test plan
- Reset, MASK=0x01, EDGE=0x01, pulse `src_irq[0]` for 1 cycle -> `hw_int`=6'b000100 two edges later, CTRL reads 0x80000000; after ACK, `hw_int`=0 and PEND=0.
- MASK=0xFF, EDGE=0xFF, pulse `src_irq[5]` and `src_irq[2]` in the same cycle -> CTRL id=2. After ACK and GAP -> id=5. With `IRQ_PRIO_ROTATE_EN` and prior grant 3, the same stimulus gives id=5 first.
- Level source 4, MASK=0x10, EDGE=0: hold `src_irq[4]` high, then drop it during ASSERT -> `hw_int` stays 1 until ACK, then IDLE finds nothing eligible and `hw_int` stays 0.
- Edge source 1: rising edge in the same cycle as a W1C of PEND bit 1 -> PEND bit 1 reads 1 afterwards (set wins). An ACK write while in IDLE -> no state change.
- Assert `reset` mid-ASSERT -> `hw_int`=0 in the same cycle, MASK, PEND and CTRL read 0, and the block resumes normally after release.
